fifo_read_ctrl: RTL and testbench

Read-side controller for the router's per-port packet FIFO memory. It tracks committed packet entries, reads each entry byte-by-byte through the memory's combinational read port, and streams the bytes out on a valid/ready byte interface toward the output link. It frees each entry to the write side once the last byte has been accepted.

---
 rtl/fifo_read_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fifo_read_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for a per-port packet FIFO. It walks each committed entry through
// the memory's combinational read port and streams the bytes out on a valid/ready link.
module fifo_read_ctrl #(
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned WIDTH     = 11,
  parameter int unsigned UWIDTH    = 8,
  parameter int unsigned PTR_SZ    = 2,
  parameter int unsigned PTR_IN_SZ = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_commit,
  output logic                 read_en,
  output logic [PTR_SZ-1:0]    raddr,
  output logic [PTR_IN_SZ-1:0] raddr_in,
  input  logic [UWIDTH-1:0]    rdata,
  output logic [UWIDTH-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 tx_last,
  output logic                 pkt_release,
  output logic [PTR_SZ:0]      count,
  output logic                 len_err,
  output logic                 ovf
);

  localparam int unsigned CntW = PTR_SZ + 1;
  localparam int unsigned IdxW = PTR_IN_SZ + 1;

  localparam logic [UWIDTH-1:0]    MaxLenU  = UWIDTH'(WIDTH - 2);
  localparam logic [PTR_IN_SZ-1:0] MaxLenI  = PTR_IN_SZ'(WIDTH - 2);
  localparam logic [CntW-1:0]      DepthCnt = CntW'(DEPTH);
  localparam logic [PTR_SZ-1:0]    LastPtr  = PTR_SZ'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLen, StSend, StDrain} state_e;

  state_e                state_q, state_d;
  logic [PTR_SZ-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [PTR_IN_SZ-1:0]  len_q, len_d;
  logic [PTR_IN_SZ-1:0]  idx_q, idx_d;
  logic [UWIDTH-1:0]     tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_last_q, tx_last_d;
  logic                  release_q, release_d;
  logic                  len_err_q, len_err_d;
  logic                  ovf_q, ovf_d;

  logic [IdxW-1:0] idx_ext;
  logic [IdxW-1:0] last_idx;
  logic            load;
  logic            is_last;

  assign idx_ext  = {1'b0, idx_q};
  assign last_idx = {1'b0, len_q} + IdxW'(1);
  assign is_last  = (idx_ext == last_idx);
  // A new byte may be loaded whenever the output register is empty or being drained.
  assign load     = (state_q == StSend) && (idx_ext <= last_idx) && (!tx_valid_q || tx_ready);

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    release_d  = 1'b0;
    len_err_d  = 1'b0;
    read_en    = 1'b0;
    raddr_in   = '0;

    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d = StLen;
        end
      end
      StLen: begin
        read_en  = 1'b1;
        raddr_in = PTR_IN_SZ'(1);
        if (rdata > MaxLenU) begin
          len_d     = MaxLenI;
          len_err_d = 1'b1;
        end else begin
          len_d = PTR_IN_SZ'(rdata);
        end
        idx_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        raddr_in = idx_q;
        if (load) begin
          read_en    = 1'b1;
          tx_data_d  = rdata;
          tx_valid_d = 1'b1;
          tx_last_d  = is_last;
          idx_d      = idx_q + PTR_IN_SZ'(1);
          if (is_last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          release_d  = 1'b1;
          rd_ptr_d   = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PTR_SZ'(1);
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Occupancy: a same-cycle commit and release cancel, so a commit is only dropped when
  // the FIFO is full and nothing is leaving.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (pkt_commit && !release_d) begin
      if (count_q == DepthCnt) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CntW'(1);
      end
    end else if (!pkt_commit && release_d) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      release_q  <= 1'b0;
      len_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      release_q  <= release_d;
      len_err_q  <= len_err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign raddr       = rd_ptr_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign tx_last     = tx_last_q;
  assign pkt_release = release_q;
  assign count       = count_q;
  assign len_err     = len_err_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: cycle table for one packet, then hand sequences for
// backpressure, wrap/full, simultaneous commit/release, length clamp and mid-packet reset.
module tb_fifo_read_ctrl;

  localparam int unsigned Depth = 3;
  localparam int unsigned Width = 11;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_commit;
  logic       read_en;
  logic [1:0] raddr;
  logic [3:0] raddr_in;
  logic [7:0] rdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;
  logic       pkt_release;
  logic [2:0] count;
  logic       len_err;
  logic       ovf;

  logic [7:0] mem [Depth][Width];
  int         checks   = 0;
  int         failures = 0;
  logic [5:0] bp_pat   = 6'b101001;  // tx_ready sequence 1,0,0,1,0,1

  fifo_read_ctrl #(
    .DEPTH    (3),
    .WIDTH    (11),
    .UWIDTH   (8),
    .PTR_SZ   (2),
    .PTR_IN_SZ(4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pkt_commit (pkt_commit),
    .read_en    (read_en),
    .raddr      (raddr),
    .raddr_in   (raddr_in),
    .rdata      (rdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .pkt_release(pkt_release),
    .count      (count),
    .len_err    (len_err),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  always_comb begin
    rdata = 8'h00;
    if (32'(raddr) < Depth && 32'(raddr_in) < Width) rdata = mem[raddr][raddr_in];
  end

  typedef struct {
    logic       commit;
    logic       ready;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       ren;
    logic [3:0] rin;
    logic       rel;
    logic [2:0] cnt;
    logic [1:0] ra;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Payload byte j of an entry is base + (j+1)*0x11.
  task automatic load_entry(input int slot, input logic [7:0] dest, input logic [7:0] len,
                            input logic [7:0] base);
    mem[slot][0] = dest;
    mem[slot][1] = len;
    for (int k = 2; k < int'(Width); k++) mem[slot][k] = base + 8'((k - 1) * 8'h11);
  endtask

  task automatic commit_pulse();
    @(negedge clk);
    pkt_commit = 1'b1;
    @(negedge clk);
    pkt_commit = 1'b0;
  endtask

  // Consume one packet from slot; n bytes expected, optional backpressure pattern.
  task automatic stream(input int slot, input int n, input bit bp, input int exp_lerr);
    int         got     = 0;
    int         rels    = 0;
    int         lerr    = 0;
    bit         stalled = 1'b0;
    logic [7:0] prev    = 8'h00;
    for (int cyc = 0; cyc < 200 && rels == 0; cyc++) begin
      @(negedge clk);
      tx_ready = bp ? bp_pat[cyc % 6] : 1'b1;
      #1;
      if (len_err) lerr++;
      if (pkt_release) rels++;
      if (stalled) begin
        check($sformatf("s%0d_stall_hold", slot), 32'(tx_data), 32'(prev));
        check($sformatf("s%0d_stall_valid", slot), 32'(tx_valid), 32'd1);
      end
      if (tx_valid && !tx_ready) check($sformatf("s%0d_stall_ren", slot), 32'(read_en), 32'd0);
      if (tx_valid && tx_ready) begin
        check($sformatf("s%0d_byte%0d", slot, got), 32'(tx_data), 32'(mem[slot][got]));
        check($sformatf("s%0d_last%0d", slot, got), 32'(tx_last), 32'(got == n - 1));
        check($sformatf("s%0d_raddr%0d", slot, got), 32'(raddr), 32'(slot));
        got++;
      end
      stalled = tx_valid && !tx_ready;
      prev    = tx_data;
    end
    check($sformatf("s%0d_nbytes", slot), 32'(got), 32'(n));
    check($sformatf("s%0d_release", slot), 32'(rels), 32'd1);
    check($sformatf("s%0d_len_err", slot), 32'(lerr), 32'(exp_lerr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  got;
    bit  hit;
    resetn     = 1'b0;
    pkt_commit = 1'b0;
    tx_ready   = 1'b0;
    for (int s = 0; s < int'(Depth); s++) load_entry(s, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_ren", 32'(read_en), 32'd0);
    resetn = 1'b1;

    // Single packet, cycle by cycle: {commit,ready,valid,data,last,ren,rin,rel,cnt,raddr}
    load_entry(0, 8'h5A, 8'd3, 8'h00);
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 2'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 3'd1, 2'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'd1, 1'b0, 3'd1, 2'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0, 3'd1, 2'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 4'd1, 1'b0, 3'd1, 2'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 4'd2, 1'b0, 3'd1, 2'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 4'd3, 1'b0, 3'd1, 2'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 4'd4, 1'b0, 3'd1, 2'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 4'd0, 1'b0, 3'd1, 2'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b1, 3'd0, 2'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 2'd1};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      pkt_commit = tbl[i].commit;
      tx_ready   = tbl[i].ready;
      #1;
      check($sformatf("v%0d_valid", i), 32'(tx_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) check($sformatf("v%0d_data", i), 32'(tx_data), 32'(tbl[i].data));
      check($sformatf("v%0d_last", i), 32'(tx_last), 32'(tbl[i].last));
      check($sformatf("v%0d_ren", i), 32'(read_en), 32'(tbl[i].ren));
      check($sformatf("v%0d_rin", i), 32'(raddr_in), 32'(tbl[i].rin));
      check($sformatf("v%0d_rel", i), 32'(pkt_release), 32'(tbl[i].rel));
      check($sformatf("v%0d_cnt", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("v%0d_raddr", i), 32'(raddr), 32'(tbl[i].ra));
    end
    pkt_commit = 1'b0;

    // Backpressure on the same packet in slot 1.
    load_entry(1, 8'h5A, 8'd3, 8'h00);
    commit_pulse();
    stream(1, 5, 1'b1, 0);

    // Length clamp: header 15 clamps to 9, so 11 bytes go out.
    load_entry(2, 8'h77, 8'd15, 8'h01);
    commit_pulse();
    stream(2, 11, 1'b0, 1);
    check("clamp_count", 32'(count), 32'd0);

    // Wrap and full: four commits with the link stalled.
    for (int s = 0; s < int'(Depth); s++) load_entry(s, 8'(8'hC0 + s), 8'd0, 8'h00);
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pkt_commit = 1'b1;
      #1;
      if (i == 3) begin
        check("full_count_pre", 32'(count), 32'd3);
        check("full_ovf_pre", 32'(ovf), 32'd0);
      end
    end
    @(negedge clk);
    pkt_commit = 1'b0;
    #1;
    check("full_count", 32'(count), 32'd3);
    check("full_ovf", 32'(ovf), 32'd1);
    check("wrap_raddr0", 32'(raddr), 32'd0);
    stream(0, 2, 1'b0, 0);
    check("wrap_raddr1", 32'(raddr), 32'd1);
    stream(1, 2, 1'b0, 0);
    check("wrap_raddr2", 32'(raddr), 32'd2);
    stream(2, 2, 1'b0, 0);
    check("wrap_raddr3", 32'(raddr), 32'd0);
    check("wrap_count", 32'(count), 32'd0);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Commit landing on the same edge as a release, with two entries stored.
    load_entry(0, 8'hD0, 8'd0, 8'h00);
    load_entry(1, 8'hD1, 8'd1, 8'h00);
    load_entry(2, 8'hD2, 8'd0, 8'h00);
    tx_ready = 1'b0;
    @(negedge clk);
    pkt_commit = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pkt_commit = 1'b0;
    #1;
    check("sim_count_pre", 32'(count), 32'd2);
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      if (tx_valid && tx_last) begin
        pkt_commit = 1'b1;
        hit        = 1'b1;
      end
    end
    check("sim_reached_drain", 32'(hit), 32'd1);
    @(negedge clk);
    pkt_commit = 1'b0;
    #1;
    check("sim_release", 32'(pkt_release), 32'd1);
    check("sim_count", 32'(count), 32'd2);
    @(negedge clk);
    #1;
    check("sim_count_after", 32'(count), 32'd2);
    stream(1, 3, 1'b0, 0);
    stream(2, 2, 1'b0, 0);
    check("sim_count_end", 32'(count), 32'd0);

    // Reset in the middle of a packet.
    load_entry(0, 8'hA0, 8'd2, 8'hA0);
    load_entry(1, 8'h5A, 8'd3, 8'h00);
    commit_pulse();
    stream(0, 4, 1'b0, 0);
    commit_pulse();
    got = 0;
    for (int c = 0; c < 40 && got < 2; c++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      #1;
      if (tx_valid && tx_ready) got++;
    end
    check("rst_mid_beats", 32'(got), 32'd2);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rstm_valid", 32'(tx_valid), 32'd0);
    check("rstm_last", 32'(tx_last), 32'd0);
    check("rstm_data", 32'(tx_data), 32'd0);
    check("rstm_rel", 32'(pkt_release), 32'd0);
    check("rstm_len_err", 32'(len_err), 32'd0);
    check("rstm_ovf", 32'(ovf), 32'd0);
    check("rstm_ren", 32'(read_en), 32'd0);
    check("rstm_raddr", 32'(raddr), 32'd0);
    check("rstm_rin", 32'(raddr_in), 32'd0);
    check("rstm_count", 32'(count), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    commit_pulse();
    stream(0, 4, 1'b0, 0);
    check("rstm_count_end", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
